// File: rtl/lenet_out_pkg.sv
// ----------------------------------------------------------------------------
// lenet_out_pkg
// Shared constants and state encoding for the LeNet5 classifier output stage
// (demux -> class_argmax_10).
//   NUM_CLASSES : number of per-class score channels
//   DATA_W      : score width in bits (matches the demux data width)
//   IDX_W       : width of a 0-based class index
//   state_e     : argmax FSM states
// ----------------------------------------------------------------------------
package lenet_out_pkg;

   localparam int NUM_CLASSES = 10;
   localparam int DATA_W      = 5;
   localparam int IDX_W       = 4;

   typedef enum logic [1:0] {
      COLLECT = 2'd0,
      SCAN    = 2'd1,
      DONE    = 2'd2
   } state_e;

endpackage

// File: rtl/argmax_cmp.sv
// ----------------------------------------------------------------------------
// argmax_cmp
// Combinational strict greater-than between two scores.
// Configuration macro: CLASS_ARGMAX_SIGNED_EN
//   defined   -> scores are two's-complement, signed compare
//   undefined -> unsigned compare (default build)
// Ports:
//   i_a  : candidate score
//   i_b  : current best score
//   o_gt : 1 when i_a > i_b
// ----------------------------------------------------------------------------
module argmax_cmp
   import lenet_out_pkg::*;
(
   input  logic [DATA_W-1:0] i_a,
   input  logic [DATA_W-1:0] i_b,
   output logic              o_gt
);

`ifdef CLASS_ARGMAX_SIGNED_EN
   assign o_gt = ($signed(i_a) > $signed(i_b));
`else
   assign o_gt = (i_a > i_b);
`endif

endmodule

// File: rtl/class_argmax_10.sv
// ----------------------------------------------------------------------------
// class_argmax_10
// Final stage of the LeNet5 classifier: captures the ten per-class scores from
// the output demux, then scans them sequentially and reports the index and
// value of the largest one on a valid/ready port.
// Configuration macro: CLASS_ARGMAX_SIGNED_EN (signed score comparison).
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset
//   score_1..score_10   : per-class scores from demux dout_1..dout_10
//   score_we            : per-channel write strobe, bit k-1 captures score_k
//   result_valid/ready  : result handshake
//   class_idx           : winning class, 0-based (0 = score_1)
//   max_score           : winning score
//   busy                : high while scanning or holding a result
//   err_drop            : sticky, a write arrived outside COLLECT
// ----------------------------------------------------------------------------
module class_argmax_10
   import lenet_out_pkg::*;
(
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic [DATA_W-1:0]      score_1,
   input  logic [DATA_W-1:0]      score_2,
   input  logic [DATA_W-1:0]      score_3,
   input  logic [DATA_W-1:0]      score_4,
   input  logic [DATA_W-1:0]      score_5,
   input  logic [DATA_W-1:0]      score_6,
   input  logic [DATA_W-1:0]      score_7,
   input  logic [DATA_W-1:0]      score_8,
   input  logic [DATA_W-1:0]      score_9,
   input  logic [DATA_W-1:0]      score_10,
   input  logic [NUM_CLASSES-1:0] score_we,
   output logic                   result_valid,
   input  logic                   result_ready,
   output logic [IDX_W-1:0]       class_idx,
   output logic [DATA_W-1:0]      max_score,
   output logic                   busy,
   output logic                   err_drop
);

   state_e                               r_state;
   state_e                               w_next_state;
   logic [NUM_CLASSES-1:0][DATA_W-1:0]   r_bank;
   logic [NUM_CLASSES-1:0][DATA_W-1:0]   w_scores;
   logic [NUM_CLASSES-1:0]               r_mask;
   logic [IDX_W-1:0]                     r_scan_idx;
   logic [IDX_W-1:0]                     r_best_idx;
   logic [DATA_W-1:0]                    r_best_val;
   logic                                 r_result_valid;
   logic                                 r_err_drop;
   logic                                 w_all_written;
   logic                                 w_last;
   logic                                 w_accept;
   logic                                 w_gt;

   assign w_scores[0] = score_1;
   assign w_scores[1] = score_2;
   assign w_scores[2] = score_3;
   assign w_scores[3] = score_4;
   assign w_scores[4] = score_5;
   assign w_scores[5] = score_6;
   assign w_scores[6] = score_7;
   assign w_scores[7] = score_8;
   assign w_scores[8] = score_9;
   assign w_scores[9] = score_10;

   // The completing write counts: strobes on this edge are OR-ed in.
   assign w_all_written = &(r_mask | score_we);
   assign w_last        = (r_scan_idx == IDX_W'(NUM_CLASSES - 1));
   assign w_accept      = (r_state == DONE) && r_result_valid && result_ready;

   argmax_cmp u_cmp (
      .i_a  (r_bank[r_scan_idx]),
      .i_b  (r_best_val),
      .o_gt (w_gt)
   );

   // FSM state register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= COLLECT;
      end else begin
         r_state <= w_next_state;
      end
   end

   // FSM next-state logic.
   always_comb begin
      w_next_state = r_state;
      case (r_state)
         COLLECT: begin
            if (w_all_written) w_next_state = SCAN;
            else               w_next_state = COLLECT;
         end
         SCAN: begin
            if (w_last) w_next_state = DONE;
            else        w_next_state = SCAN;
         end
         DONE: begin
            if (w_accept) w_next_state = COLLECT;
            else          w_next_state = DONE;
         end
         default: w_next_state = COLLECT;
      endcase
   end

   // Score bank, written mask, scan pointer and result registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_bank         <= '0;
         r_mask         <= '0;
         r_scan_idx     <= '0;
         r_best_idx     <= '0;
         r_best_val     <= '0;
         r_result_valid <= 1'b0;
      end else begin
         case (r_state)
            COLLECT: begin
               for (int k = 0; k < NUM_CLASSES; k++) begin
                  if (score_we[k]) r_bank[k] <= w_scores[k];
               end
               r_mask     <= r_mask | score_we;
               r_scan_idx <= '0;
            end
            SCAN: begin
               // Entry 0 seeds the running best; later entries must be
               // strictly larger so ties keep the lowest index.
               if ((r_scan_idx == '0) || w_gt) begin
                  r_best_val <= r_bank[r_scan_idx];
                  r_best_idx <= r_scan_idx;
               end
               if (w_last) r_result_valid <= 1'b1;
               else        r_scan_idx     <= r_scan_idx + IDX_W'(1);
            end
            DONE: begin
               if (w_accept) begin
                  r_result_valid <= 1'b0;
                  r_mask         <= '0;
               end
            end
            default: begin
               r_result_valid <= 1'b0;
            end
         endcase
      end
   end

   // Sticky dropped-write flag; writes are only accepted in COLLECT.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_err_drop <= 1'b0;
      end else if ((r_state != COLLECT) && (|score_we)) begin
         r_err_drop <= 1'b1;
      end else begin
         r_err_drop <= r_err_drop;
      end
   end

   assign result_valid = r_result_valid;
   assign class_idx    = r_best_idx;
   assign max_score    = r_best_val;
   assign err_drop     = r_err_drop;
   assign busy         = (r_state == SCAN) || (r_state == DONE);

endmodule
